serial_subtractor_32: RTL and testbench
=======================================

# serial_subtractor_32

Two-cycle, handshaked 32-bit subtractor computing D = A − B − bin with a single 16-bit lane reused over two cycles: low half first, then high half. It is the subtract-side counterpart of the 32-bit split-capable adder in the datapath. It supports the same split mode: either one 32-bit operation, or two independent 16-bit lanes with the inter-lane borrow broken. Sits between the operand-issue stage and the result writeback stage, with valid/ready handshakes on both sides.

## Interface
- LANE_W, 16, width of the shared subtract lane (fixed; WORD_W = 2*LANE_W)
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous and active-low
- in_valid  in  1  operand request valid
- in_ready  out  1  block can accept operands
- a  in  32  minuend, bits [15:0] low lane, [31:16] high lane
- b  in  32  subtrahend, same lane mapping
- bin  in  1  borrow-in to the low lane
- split  in  1  1 = two independent 16-bit lanes (high lane borrow-in forced 0); 0 = full 32-bit chain
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- d  out  32  difference
- lo_bout  out  1  borrow-out of the low lane
- bout  out  1  borrow-out of the high lane
- ovf_lo  out  1  signed overflow of the low lane (see Configuration)
- ovf_hi  out  1  signed overflow of the high lane / full word

## Operation
- FSM states: IDLE, LOW, HIGH, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, latch a, b, bin, split, then go to LOW. Inputs may change freely after acceptance.
- LOW: lane computes a[15:0] − b[15:0] − bin. Register d[15:0] and lo_bout. Go to HIGH.
- HIGH: high-lane borrow-in = split ? 0 : lo_bout. Lane computes a[31:16] − b[31:16] − borrow-in. Register d[31:16] and bout. Go to DONE.
- DONE: out_valid=1. d, bout, lo_bout and ovf_* are held stable until out_ready.
  - out_ready=0: stay in DONE.
  - out_ready=1, in_valid=0: go to IDLE.
  - out_ready=1, in_valid=1: new operands are accepted in the same cycle and the FSM goes directly to LOW (back-to-back).
- in_ready = (state==IDLE) | (state==DONE & out_ready). This is a combinational path from out_ready to in_ready.
- Arithmetic is modulo 2^16 per lane. A borrow is 1 when the unsigned minuend is less than subtrahend + borrow-in.
- Reset (asynchronous, any state including mid-operation):
  - state goes to IDLE;
  - out_valid=0;
  - d, bout, lo_bout, ovf_lo, ovf_hi and all latched operands go to 0.
  - The in-flight operation is discarded; no result is produced for it.

## Timing
- Accept at edge E0. The low half is registered at E1. The high half is registered at E2. out_valid is high from E2 until the handshake edge.
- Latency is 2 cycles from accept to out_valid.
- Minimum initiation interval is 3 cycles with out_ready tied high. The cycle in DONE overlaps the next accept.
- in_ready is 0 during LOW and HIGH.
- d[15:0] is updated at E1, before out_valid rises. Consumers sample only when out_valid=1.

## Configuration
- SUB_OVERFLOW_EN defined:
  - ovf_lo = sign(a_lo) ≠ sign(b_lo) & sign(d_lo) ≠ sign(a_lo), registered with the low half.
  - ovf_hi uses the same rule on the high lane, registered with the high half.
  - In non-split mode, ovf_hi is the 32-bit signed overflow.
- SUB_OVERFLOW_EN undefined: ovf_lo and ovf_hi ports are present but tied to 0, and no overflow logic is instantiated.

## Structure
- Package sub_pkg holds:
  - LANE_W = 16 and WORD_W = 32 localparams;
  - state enum typedef sub_state_t {IDLE, LOW, HIGH, DONE};
  - a lane result struct (diff[15:0], bout, ovf).
- One sub-module, sixteen_bit_subtractor:
  - purely combinational, instantiated once;
  - inputs a, b, borrow-in; outputs diff, borrow-out, overflow.
  - The top module muxes lane operands by state.

## Test plan
- a=0x0001_0000, b=0x0000_0001, bin=0, split=0 -> d=0x0000_FFFF, lo_bout=1, bout=0, out_valid exactly 2 cycles after accept.
- Same operands, split=1 -> d=0x0001_FFFF, lo_bout=1, bout=0 (borrow not propagated).
- a=0, b=0, bin=1, split=0 -> d=0xFFFF_FFFF, lo_bout=1, bout=1.
- Hold out_ready=0 for 5 cycles in DONE -> d and out_valid stable, in_ready=0. Then out_ready=1 with in_valid=1 -> new operands accepted that cycle, next result 2 cycles later.
- Assert rst_n=0 while in HIGH -> out_valid=0 and d=0 immediately (asynchronous). After release, in_ready=1 and no stale result appears.
- With SUB_OVERFLOW_EN: a=0x8000_0000, b=0x0000_0001, split=0 -> d=0x7FFF_FFFF, ovf_hi=1, ovf_lo=0. Without the macro: ovf_hi=0.

Source files
------------

// File: rtl/sub_pkg.sv
// Shared types and widths for the two-cycle serial subtractor.
package sub_pkg;

  localparam int LANE_W = 16;
  localparam int WORD_W = 2 * LANE_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } sub_state_t;

  // One pass of the shared lane: difference, borrow-out, signed overflow
  typedef struct packed {
    logic [LANE_W-1:0] diff;
    logic              bout;
    logic              ovf;
  } lane_res_t;

endpackage

// File: rtl/sixteen_bit_subtractor.sv
// Combinational 16-bit lane: diff = a - b - bin, with borrow-out and signed
// overflow. Overflow logic exists only when SUB_OVERFLOW_EN is defined;
// otherwise ovf is tied to 0.
module sixteen_bit_subtractor
  import sub_pkg::*;
(
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  input  logic              bin,
  output logic [LANE_W-1:0] diff,
  output logic              bout,
  output logic              ovf
);

  logic [LANE_W:0] full;

  // Extended subtract: the extra MSB goes to 1 exactly when a < b + bin
  always_comb begin
    full = {1'b0, a} - {1'b0, b} - {{LANE_W{1'b0}}, bin};
  end

  assign diff = full[LANE_W-1:0];
  assign bout = full[LANE_W];

`ifdef SUB_OVERFLOW_EN
  // Operand signs differ and the result sign left the minuend's sign
  assign ovf = (a[LANE_W-1] ^ b[LANE_W-1]) & (diff[LANE_W-1] ^ a[LANE_W-1]);
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/serial_subtractor_32.sv
// 32-bit subtractor D = A - B - bin built from one 16-bit lane used twice:
// low half in LOW, high half in HIGH. split=1 breaks the inter-lane borrow.
// Optional macro SUB_OVERFLOW_EN enables signed-overflow flags ovf_lo/ovf_hi;
// without it both ports read 0.
module serial_subtractor_32
  import sub_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              bin,
  input  logic              split,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] d,
  output logic              lo_bout,
  output logic              bout,
  output logic              ovf_lo,
  output logic              ovf_hi
);

  sub_state_t        state_q, state_d;
  logic              accept;

  logic [WORD_W-1:0] a_q, b_q;
  logic              bin_q, split_q;

  logic [WORD_W-1:0] d_q;
  logic              lo_bout_q, bout_q;

  logic [LANE_W-1:0] lane_a, lane_b;
  logic              lane_bin;
  lane_res_t         lane_res;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake; DONE with out_ready overlaps the next accept
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = LOW;
      end
      LOW:  state_d = HIGH;
      HIGH: state_d = DONE;
      DONE: begin
        if (out_ready) begin
          in_ready = 1'b1;
          state_d  = in_valid ? LOW : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == DONE);

  // Operand latch; callers may change a/b after the accept edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      bin_q   <= 1'b0;
      split_q <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      bin_q   <= bin;
      split_q <= split;
    end
  end

  // Lane operand mux: high half takes the low-lane borrow unless split
  always_comb begin
    lane_a   = a_q[LANE_W-1:0];
    lane_b   = b_q[LANE_W-1:0];
    lane_bin = bin_q;
    if (state_q == HIGH) begin
      lane_a   = a_q[WORD_W-1:LANE_W];
      lane_b   = b_q[WORD_W-1:LANE_W];
      lane_bin = ~split_q & lo_bout_q;
    end
  end

  sixteen_bit_subtractor u_lane (
    .a    (lane_a),
    .b    (lane_b),
    .bin  (lane_bin),
    .diff (lane_res.diff),
    .bout (lane_res.bout),
    .ovf  (lane_res.ovf)
  );

  // Result halves are captured in the state that computed them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q       <= '0;
      lo_bout_q <= 1'b0;
      bout_q    <= 1'b0;
    end else if (state_q == LOW) begin
      d_q[LANE_W-1:0] <= lane_res.diff;
      lo_bout_q       <= lane_res.bout;
    end else if (state_q == HIGH) begin
      d_q[WORD_W-1:LANE_W] <= lane_res.diff;
      bout_q               <= lane_res.bout;
    end
  end

  assign d       = d_q;
  assign lo_bout = lo_bout_q;
  assign bout    = bout_q;

`ifdef SUB_OVERFLOW_EN
  logic ovf_lo_q, ovf_hi_q;

  // Overflow flags ride along with their half; in chained mode the high
  // lane's flag is the 32-bit signed overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_lo_q <= 1'b0;
      ovf_hi_q <= 1'b0;
    end else if (state_q == LOW) begin
      ovf_lo_q <= lane_res.ovf;
    end else if (state_q == HIGH) begin
      ovf_hi_q <= lane_res.ovf;
    end
  end

  assign ovf_lo = ovf_lo_q;
  assign ovf_hi = ovf_hi_q;
`else
  // Lane overflow is constant 0 in this build
  assign ovf_lo = lane_res.ovf;
  assign ovf_hi = lane_res.ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor_32.sv
// Directed bench for serial_subtractor_32: vector table plus stall,
// back-to-back and mid-operation reset sequences.
module tb_serial_subtractor_32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] a, b;
  logic        bin, split;
  logic        out_valid, out_ready;
  logic [31:0] d;
  logic        lo_bout, bout, ovf_lo, ovf_hi;

  int n_cmp = 0;
  int n_err = 0;

`ifdef SUB_OVERFLOW_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  serial_subtractor_32 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .split     (split),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .lo_bout   (lo_bout),
    .bout      (bout),
    .ovf_lo    (ovf_lo),
    .ovf_hi    (ovf_hi)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic        split;
    logic [31:0] d;
    logic        lo;
    logic        bo;
    logic        ovl;
    logic        ovh;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one request at a negedge; the following posedge accepts it
  task automatic drive(input vec_t v);
    in_valid = 1'b1;
    a = v.a; b = v.b; bin = v.bin; split = v.split;
  endtask

  task automatic scramble();
    in_valid = 1'b0;
    a = $urandom; b = $urandom; bin = 1'($urandom); split = 1'($urandom);
  endtask

  task automatic chk_result(input string tag, input vec_t v);
    chk({tag, ".d"},       d,       v.d);
    chk({tag, ".lo_bout"}, {31'b0, lo_bout}, {31'b0, v.lo});
    chk({tag, ".bout"},    {31'b0, bout},    {31'b0, v.bo});
    chk({tag, ".ovf_lo"},  {31'b0, ovf_lo},  {31'b0, v.ovl & OVF_EN});
    chk({tag, ".ovf_hi"},  {31'b0, ovf_hi},  {31'b0, v.ovh & OVF_EN});
  endtask

  initial begin
    //            a             b             bin   split d             lo    bo    ovl   ovh
    vecs[0] = '{32'h0001_0000, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_FFFF, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'h0001_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h0001_FFFF, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h0123_4567, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{32'h0000_8000, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_7FFF, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{32'h7FFF_0000, 32'hFFFF_0000, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{32'h0000_0000, 32'h0001_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; bin = 1'b0; split = 1'b0;

    // Reset state
    #2;
    chk("rst.out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst.in_ready",  {31'b0, in_ready},  32'd1);
    chk("rst.d",         d,                  32'd0);
    chk("rst.bout",      {30'b0, lo_bout, bout}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table: accept, check latency of exactly 2 cycles, check result, drain
    for (int i = 0; i < 8; i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      drive(vecs[i]);
      chk({tag, ".in_ready"}, {31'b0, in_ready}, 32'd1);
      @(negedge clk);            // after E0
      scramble();
      chk({tag, ".busy_lo"}, {30'b0, in_ready, out_valid}, 32'd0);
      @(negedge clk);            // after E1
      chk({tag, ".busy_hi"}, {30'b0, in_ready, out_valid}, 32'd0);
      @(negedge clk);            // after E2
      chk({tag, ".out_valid"}, {31'b0, out_valid}, 32'd1);
      chk_result(tag, vecs[i]);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, ".drained"}, {31'b0, out_valid}, 32'd0);
    end

    // Stall in DONE for 5 cycles, then back-to-back accept on release
    drive(vecs[4]);
    @(negedge clk); scramble();
    @(negedge clk); @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d.out_valid", k), {31'b0, out_valid}, 32'd1);
      chk($sformatf("stall%0d.in_ready", k),  {31'b0, in_ready},  32'd0);
      chk($sformatf("stall%0d.d", k),         d,                  vecs[4].d);
      @(negedge clk);
    end
    out_ready = 1'b1;
    drive(vecs[0]);
    #1;
    chk("b2b.in_ready_comb", {31'b0, in_ready}, 32'd1);
    @(negedge clk);              // handshake + accept edge
    scramble(); out_ready = 1'b0;
    chk("b2b.out_valid_e0", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    chk("b2b.out_valid_e1", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    chk("b2b.out_valid_e2", {31'b0, out_valid}, 32'd1);
    chk_result("b2b", vecs[0]);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Asynchronous reset while in HIGH: low half is already written
    drive(vecs[0]);
    @(negedge clk); scramble();
    @(negedge clk);              // now in HIGH, d[15:0] = FFFF
    chk("rsthigh.pre_dlo", {16'b0, d[15:0]}, 32'h0000_FFFF);
    #2 rst_n = 1'b0;
    #1;
    chk("rsthigh.out_valid", {31'b0, out_valid}, 32'd0);
    chk("rsthigh.d",         d,                  32'd0);
    chk("rsthigh.lo_bout",   {31'b0, lo_bout},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rsthigh.idle%0d.in_ready", k), {31'b0, in_ready}, 32'd1);
      chk($sformatf("rsthigh.idle%0d.no_stale", k), {31'b0, out_valid}, 32'd0);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
